// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FWFT FIFO readout arbiter.
// Holds the FSM state encoding, the burst counter width and a wrap-around helper.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int BURST_CNT_W = 4;

   // (base + offs) modulo n, for base < n and offs <= n
   function automatic int wrap_add(input int base, input int offs, input int n);
      int sum;
      sum = base + offs;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Rotate-priority search: first set request at or above start, wrapping at N.
// Purely combinational; found is low when no request bit is set.
module rr_select
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;

   // bit k of req_rot is request (start + k) mod N
   assign req_dbl = {req, req} >> start;
   assign req_rot = req_dbl[N-1:0];

   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            index = IW'(wrap_add(int'(start), k, N));
         end
      end
   end

endmodule

// File: rtl/fifo_rr_readout.sv
// Round-robin readout of NSRC first-word-fall-through FIFOs into one valid/ready
// stream, taking up to MAX_BURST words from a source per grant.
module fifo_rr_readout
   import fifo_arb_pkg::*;
#(
   parameter int NSRC      = 4,
   parameter int DWIDTH    = 8,
   parameter int MAX_BURST = 4,
   localparam int IW       = $clog2(NSRC)
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   enable,
   input  logic [NSRC-1:0]        src_empty,
   input  logic [NSRC*DWIDTH-1:0] src_data,
   output logic [NSRC-1:0]        src_read,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DWIDTH-1:0]      m_data,
   output logic [IW-1:0]          m_src,
   output logic                   busy
);

   arb_state_t             state_reg;
   logic [IW-1:0]          grant_reg;
   logic [IW-1:0]          rr_ptr_reg;
   logic [BURST_CNT_W-1:0] burst_cnt_reg;
   logic                   m_valid_reg;
   logic [DWIDTH-1:0]      m_data_reg;
   logic [IW-1:0]          m_src_reg;

   logic [DWIDTH-1:0]      src_word [NSRC];
   logic [NSRC-1:0]        src_req;
   logic                   sel_found;
   logic [IW-1:0]          sel_index;
   logic                   grant_empty;
   logic                   take;
   logic                   last_word;
   logic [IW-1:0]          ptr_next;

   assign grant_empty = src_empty[grant_reg];
   assign take        = (state_reg == BURST) && !grant_empty && (!m_valid_reg || m_ready);
   assign last_word   = (burst_cnt_reg == BURST_CNT_W'(MAX_BURST - 1));
   assign ptr_next    = IW'(wrap_add(int'(grant_reg), 1, NSRC));
   assign src_req     = ~src_empty;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         assign src_word[gi] = src_data[gi*DWIDTH +: DWIDTH];
         // only the granted source can ever see its strobe, so this is one-hot or zero
         assign src_read[gi] = take && (grant_reg == IW'(gi));
      end
   endgenerate

   rr_select #(
      .N  (NSRC),
      .IW (IW)
   ) u_rr_select (
      .req   (src_req),
      .start (rr_ptr_reg),
      .found (sel_found),
      .index (sel_index)
   );

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         burst_cnt_reg <= '0;
         m_valid_reg   <= 1'b0;
         m_data_reg    <= '0;
         m_src_reg     <= '0;
      end else begin
         // output register: load on take, otherwise drain when accepted
         if (take) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= src_word[grant_reg];
            m_src_reg   <= grant_reg;
         end else if (m_ready) begin
            m_valid_reg <= 1'b0;
         end

         if (state_reg == IDLE) begin
            if (enable && sel_found) begin
               grant_reg     <= sel_index;
               burst_cnt_reg <= '0;
               state_reg     <= BURST;
            end
         end else begin
            if (take) begin
               burst_cnt_reg <= burst_cnt_reg + BURST_CNT_W'(1);
            end
            // enable is deliberately ignored here: a running burst always completes
            if ((take && last_word) || grant_empty) begin
               state_reg  <= IDLE;
               rr_ptr_reg <= ptr_next;
            end
         end
      end
   end

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_src   = m_src_reg;
   assign busy    = (state_reg == BURST);

endmodule
